// File: rtl/sub_seq_ctrl.sv
// Wide subtract sequencer: streams W=16*WORDS operands one 16-bit word per cycle through a shared subtractor, LSW first, borrow chained.
// Latency: rsp_valid rises WORDS edges after the accepting edge (WORDS RUN cycles, then DONE); WORDS+2 cycles per op with rsp_ready held high.
// Backpressure: DONE holds results stable until rsp_ready; req_ready is low outside IDLE (SUB_SEQ_BACK2BACK_EN: follows rsp_ready in DONE).
module sub_seq_ctrl #(
    parameter int WORDS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [16*WORDS-1:0] req_a,
    input  logic [16*WORDS-1:0] req_b,
    input  logic                req_bin,
    output logic [15:0]         dp_a,
    output logic [15:0]         dp_b,
    output logic                dp_bin,
    input  logic [15:0]         dp_diff,
    input  logic                dp_bout,
    output logic                dp_clk_en,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [16*WORDS-1:0] rsp_diff,
    output logic                rsp_bout,
    output logic                rsp_zero,
    output logic                rsp_ovf
);

    localparam int W  = 16 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   idx;
    logic [W-1:0]    a_reg, b_reg, res_reg;
    logic            borrow_reg, zero_acc;
    logic [15:0]     dp_a_q, dp_b_q;
    logic            dp_bin_q;
    logic [15:0]     word_a, word_b;
    logic [IW+3:0]   bit_ofs;
    logic            last_word, accept, in_run;

    assign bit_ofs   = {idx, 4'b0000};
    assign word_a    = 16'(a_reg >> bit_ofs);
    assign word_b    = 16'(b_reg >> bit_ofs);
    assign last_word = (idx == IW'(WORDS - 1));
    assign in_run    = (state == RUN);
    assign accept    = req_valid & req_ready;

    // Datapath operands track the current word in RUN and freeze otherwise so the gated datapath sees no toggling.
    assign dp_a   = in_run ? word_a     : dp_a_q;
    assign dp_b   = in_run ? word_b     : dp_b_q;
    assign dp_bin = in_run ? borrow_reg : dp_bin_q;

    assign rsp_diff = res_reg;
    assign rsp_bout = borrow_reg;
    assign rsp_zero = zero_acc;
    assign rsp_ovf  = (a_reg[W-1] != b_reg[W-1]) & (res_reg[W-1] != a_reg[W-1]);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake/gating outputs; req_ready is forced low while reset is asserted.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        dp_clk_en = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = rst_n;
                if (req_valid) state_nxt = RUN;
            end
            RUN: begin
                dp_clk_en = 1'b1;
                if (last_word) state_nxt = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
`ifdef SUB_SEQ_BACK2BACK_EN
                req_ready = rsp_ready;
                if (rsp_ready) state_nxt = req_valid ? RUN : IDLE;
`else
                if (rsp_ready) state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture on accept; per-word result, borrow chain and zero tracking while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            res_reg    <= '0;
            borrow_reg <= 1'b0;
            zero_acc   <= 1'b0;
            idx        <= '0;
            dp_a_q     <= '0;
            dp_b_q     <= '0;
            dp_bin_q   <= 1'b0;
        end else if (accept) begin
            a_reg      <= req_a;
            b_reg      <= req_b;
            borrow_reg <= req_bin;
            zero_acc   <= 1'b1;
            idx        <= '0;
        end else if (in_run) begin
            res_reg    <= (res_reg & ~(W'(16'hFFFF) << bit_ofs)) | (W'(dp_diff) << bit_ofs);
            borrow_reg <= dp_bout;
            zero_acc   <= zero_acc & (dp_diff == 16'h0000);
            idx        <= last_word ? '0 : idx + 1'b1;
            dp_a_q     <= word_a;
            dp_b_q     <= word_b;
            dp_bin_q   <= borrow_reg;
        end
    end

endmodule
